pipe_hazard_ctrl: RTL

- Parametrised pipeline hazard controller for the in-order core. Generates per-stage stall and flush vectors from the exception, branch, memory-wait, execute-wait, issue-queue-full and fetch-wait events.
- Replaces one-shot "redirect while fetch busy" flags with an outstanding-fetch counter. After any redirect, every stale in-flight I-cache response is squashed, however many fetches were in flight.
- Sits beside the datapath. All outputs drive the pipeline-register enables and clears directly.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl_fetch_squash_ctr.sv | 59 +++++
 rtl/pipe_hazard_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// the per-stage control bundle and a small range helper for the decode.
package pipe_hazard_ctrl_pkg;

    localparam int NSTAGE_DEF = 8;

    // Pipeline register indices for the default in-order core.
    localparam int STG_F1 = 0;
    localparam int STG_F2 = 1;
    localparam int STG_D  = 2;
    localparam int STG_I  = 3;
    localparam int STG_E  = 4;
    localparam int STG_M  = 5;
    localparam int STG_M2 = 6;
    localparam int STG_W  = 7;

    // Control bundle driven onto the pipeline-register enables and clears.
    typedef struct packed {
        logic [NSTAGE_DEF-1:0] stall;
        logic [NSTAGE_DEF-1:0] flush;
        logic                  flush_que;
    } hazard_ctrl_t;

    // True when stage idx lies in the inclusive range [lo, hi].
    function automatic logic in_range(input int idx, input int lo, input int hi);
        return (idx >= lo) && (idx <= hi);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Event/control bundle between the datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE = NSTAGE_DEF
) ();

    logic              excp_early;
    logic              excp_late;
    logic              branch_redirect;
    logic              d_wait;
    logic              e_wait;
    logic              q_full;
    logic              i_wait;
    logic              ifetch_fire;
    logic              iresp_valid;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] flush;
    logic              flush_que;
    logic              drop_resp;
    logic              redirect_busy;

    modport master (
        output excp_early, excp_late, branch_redirect, d_wait, e_wait,
               q_full, i_wait, ifetch_fire, iresp_valid,
        input  stall, flush, flush_que, drop_resp, redirect_busy
    );

    modport slave (
        input  excp_early, excp_late, branch_redirect, d_wait, e_wait,
               q_full, i_wait, ifetch_fire, iresp_valid,
        output stall, flush, flush_que, drop_resp, redirect_busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fetch_squash_ctr.sv
// Tracks outstanding I-fetch requests and, after a redirect, how many of
// them are stale and must have their responses discarded.
module fetch_squash_ctr
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_redirect,
    input  logic i_ifetch_fire,
    input  logic i_iresp_valid,
    output logic o_drop_resp,
    output logic o_redirect_busy
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    logic [CW-1:0] r_out_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_out_cnt_next;
    logic [CW-1:0] w_drop_cnt_next;
    logic          w_drop_pending;

    assign w_out_cnt_next = r_out_cnt + CW'(i_ifetch_fire) - CW'(i_iresp_valid);
    assign w_drop_pending = (r_drop_cnt != '0);

    // A redirect marks everything in flight (including a fetch fired this
    // cycle) as stale; the load replaces any squash already in progress.
    always_comb begin
        w_drop_cnt_next = r_drop_cnt;
        if (i_redirect) begin
            w_drop_cnt_next = w_out_cnt_next;
        end else if (i_iresp_valid && w_drop_pending) begin
            w_drop_cnt_next = r_drop_cnt - CW'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_out_cnt  <= w_out_cnt_next;
            r_drop_cnt <= w_drop_cnt_next;
        end
    end

    assign o_drop_resp     = i_iresp_valid & (i_redirect | w_drop_pending);
    assign o_redirect_busy = w_drop_pending;

    a_out_cnt_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_ifetch_fire && !i_iresp_valid && (r_out_cnt == MAX_C)));
    a_out_cnt_underflow: assert property (@(posedge clk) disable iff (reset)
        !(i_iresp_valid && !i_ifetch_fire && (r_out_cnt == '0)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritised stall/flush decode plus the
// stale-fetch squash counter. Outputs are combinational from events and state.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NSTAGE    = NSTAGE_DEF,
    parameter int QUE_STAGE = STG_I,
    parameter int EX_STAGE  = STG_E,
    parameter int BR_STAGE  = STG_M,
    parameter int MEM_STAGE = STG_M,
    parameter int MAX_OUT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    logic              w_excp;
    logic              w_redirect;
    logic              w_drop_resp;
    logic              w_redirect_busy;
    logic [NSTAGE-1:0] w_stall;
    logic [NSTAGE-1:0] w_flush;
    logic              w_flush_que;

    assign w_excp     = hz.excp_early | hz.excp_late;
    // A branch behind a D-cache wait is not taken until the wait clears.
    assign w_redirect = w_excp | (hz.branch_redirect & ~hz.d_wait);

    fetch_squash_ctr #(
        .MAX_OUT (MAX_OUT)
    ) u_squash (
        .clk             (clk),
        .reset           (reset),
        .i_redirect      (w_redirect),
        .i_ifetch_fire   (hz.ifetch_fire),
        .i_iresp_valid   (hz.iresp_valid),
        .o_drop_resp     (w_drop_resp),
        .o_redirect_busy (w_redirect_busy)
    );

    // Priority decode of hazard events into stall/flush range fills; a
    // dropped response additionally clears F2 and D.
    always_comb begin
        w_stall     = '0;
        w_flush     = '0;
        w_flush_que = 1'b0;
        if (w_excp) begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (in_range(s, 1, MEM_STAGE)) w_flush[s] = 1'b1;
                if (hz.excp_late && in_range(s, MEM_STAGE + 1, NSTAGE - 1)) w_flush[s] = 1'b1;
            end
            w_flush_que = 1'b1;
            if (hz.i_wait) w_stall[STG_F1] = 1'b1;
        end else if (hz.d_wait) begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (in_range(s, 0, MEM_STAGE)) w_stall[s] = 1'b1;
                if (s == MEM_STAGE + 1) w_flush[s] = 1'b1;
            end
        end else if (hz.branch_redirect) begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (in_range(s, 1, BR_STAGE)) w_flush[s] = 1'b1;
            end
            w_flush_que = 1'b1;
            if (hz.i_wait) w_stall[STG_F1] = 1'b1;
        end else if (hz.e_wait) begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (in_range(s, 0, EX_STAGE)) w_stall[s] = 1'b1;
                if (s == EX_STAGE + 1) w_flush[s] = 1'b1;
            end
        end else if (hz.q_full) begin
            for (int s = 0; s < NSTAGE; s++) begin
                if (in_range(s, 0, QUE_STAGE)) w_stall[s] = 1'b1;
            end
        end else if (hz.i_wait) begin
            w_stall[STG_F1] = 1'b1;
            w_flush[STG_F2] = 1'b1;
        end
        if (w_drop_resp) begin
            w_flush[STG_F2] = 1'b1;
            w_flush[STG_D]  = 1'b1;
        end
    end

    assign hz.stall         = w_stall;
    assign hz.flush         = w_flush;
    assign hz.flush_que     = w_flush_que;
    assign hz.drop_resp     = w_drop_resp;
    assign hz.redirect_busy = w_redirect_busy;

endmodule
